// File: rtl/crc_sequencer.sv
// Serialises a WIDTH-bit message MSB-first into an external CRC engine and returns its FEC; define CRC_SEQ_TIMEOUT_EN for a bounded WAIT.
// Start pulse 1 cycle after acceptance, bits in the next WIDTH cycles; in_ready only in IDLE, result held until out_ready.
module crc_sequencer #(
    parameter int WIDTH   = 48,
    parameter int TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_word,
    output logic             in_ready,
    output logic             crc_start,
    output logic             crc_data,
    input  logic             crc_done,
    input  logic [WIDTH-1:0] crc_fec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] fec_out,
    output logic             out_err
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, SHIFT, WAIT, RESULT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] fec_q, fec_d;
`ifdef CRC_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0]    wcnt_q, wcnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        fec_d     = fec_q;
`ifdef CRC_SEQ_TIMEOUT_EN
        wcnt_d    = wcnt_q;
        err_d     = err_q;
`endif
        crc_start = 1'b0;
        crc_data  = 1'b0;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == RESULT);

        // The engine may finish while bits are still streaming; remember it for WAIT.
        if ((state_q == SHIFT || state_q == WAIT) && crc_done) begin
            done_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sreg_d  = in_word;
                    done_d  = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                crc_start = 1'b1;
                cnt_d     = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                crc_data = sreg_q[WIDTH-1];
                sreg_d   = sreg_q << 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = WAIT;
`ifdef CRC_SEQ_TIMEOUT_EN
                    wcnt_d  = '0;
`endif
                end
            end
            WAIT: begin
                if (done_q || crc_done) begin
                    fec_d   = crc_fec;
`ifdef CRC_SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = RESULT;
                end
`ifdef CRC_SEQ_TIMEOUT_EN
                else if (wcnt_q == WAIT_LAST) begin
                    fec_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESULT;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            RESULT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fec_out = fec_q;
`ifdef CRC_SEQ_TIMEOUT_EN
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            fec_q   <= '0;
`ifdef CRC_SEQ_TIMEOUT_EN
            wcnt_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            fec_q   <= fec_d;
`ifdef CRC_SEQ_TIMEOUT_EN
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        assert (WIDTH > 1 && TIMEOUT > 0);
    end
endmodule

// File: tb/tb_crc_sequencer.sv
// Randomised bench for crc_sequencer: cycle-indexed traces compared against a bit-position model of the message stream.
module tb_crc_sequencer;
    localparam int W    = 48;
    localparam int TO   = 64;
    localparam int MAXC = 400;
`ifdef CRC_SEQ_TIMEOUT_EN
    localparam bit HAS_TO = 1'b1;
`else
    localparam bit HAS_TO = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_word = '0;
    logic         in_ready;
    logic         crc_start;
    logic         crc_data;
    logic         crc_done = 1'b0;
    logic [W-1:0] crc_fec = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] fec_out;
    logic         out_err;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic start_tr [0:MAXC-1];
    logic data_tr  [0:MAXC-1];

    crc_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_word(in_word),
        .in_ready(in_ready), .crc_start(crc_start), .crc_data(crc_data),
        .crc_done(crc_done), .crc_fec(crc_fec), .out_valid(out_valid),
        .out_ready(out_ready), .fec_out(fec_out), .out_err(out_err)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] rand_word();
        return W'({$urandom, $urandom});
    endfunction

    // Cycle 0 = acceptance; start in cycle 1; bit k (0 = MSB) in cycle k+2; everything else idle-low.
    function automatic int trace_errs(input logic [W-1:0] word, input int last);
        int errs = 0;
        for (int c = 0; c <= last && c < MAXC; c++) begin
            logic exp_s;
            logic exp_d;
            exp_s = (c == 1);
            exp_d = (c >= 2 && c <= W + 1) ? word[W + 1 - c] : 1'b0;
            if (start_tr[c] !== exp_s || data_tr[c] !== exp_d) errs++;
        end
        return errs;
    endfunction

    // Cycle in which out_valid first shows, given the cycle crc_done pulses (-1: never).
    function automatic int exp_res(input int d);
        int first_wait = W + 2;
        if (d >= 2 && d <= first_wait) return W + 3;
        if (d > first_wait && (!HAS_TO || d - first_wait < TO)) return d + 1;
        return HAS_TO ? first_wait + TO : -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        crc_done = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
    endtask

    // Offers word, pulses crc_done in cycle done_cyc, records traces until out_valid or budget expires.
    task automatic run_req(input logic [W-1:0] word, input int done_cyc, input logic [W-1:0] fec,
                           input int budget, output int res_cyc);
        int n = 0;
        res_cyc = -1;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < MAXC; i++) begin
            start_tr[i] = 1'b0;
            data_tr[i]  = 1'b0;
        end
        crc_fec = fec;
        in_word = word;
        in_valid = 1'b1;
        start_tr[0] = crc_start;
        data_tr[0]  = crc_data;
        for (int c = 1; c <= budget && res_cyc < 0; c++) begin
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            in_word  = rand_word();
            crc_done = (c == done_cyc);
            @(negedge clock);
            if (c < MAXC) begin
                start_tr[c] = crc_start;
                data_tr[c]  = crc_data;
            end
            if (out_valid === 1'b1) res_cyc = c;
        end
        crc_done = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_word  = rand_word();
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1 || crc_start !== 1'b0) begin
            fails++;
            $display("FAIL reset_priority: in_ready=%b crc_start=%b, required 1 0", in_ready, crc_start);
        end else passes++;
        in_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end else passes++;
        checks++;
        if (out_valid !== 1'b0 || crc_start !== 1'b0 || crc_data !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: out_valid=%b crc_start=%b crc_data=%b, required 0 0 0",
                     out_valid, crc_start, crc_data);
        end else passes++;
        checks++;
        if (fec_out !== '0 || out_err !== 1'b0) begin
            fails++; $display("FAIL reset_result: fec_out=%h out_err=%b, required 0 0", fec_out, out_err);
        end else passes++;
    endtask

    task automatic test_directed_frame();
        logic [W-1:0] word = 48'h03_01_02_03_30_3A;
        logic [W-1:0] fec  = 48'h1234_5678_9ABC;
        logic [7:0]   first8;
        logic [7:0]   want8 = 8'b0000_0011;
        int res;
        run_req(word, W + 4, fec, 200, res);
        for (int k = 0; k < 8; k++) first8[7 - k] = data_tr[k + 2];
        checks++;
        if (first8 !== want8) begin
            fails++; $display("FAIL directed_first_bits: got %b, required %b", first8, want8);
        end else passes++;
        checks++;
        if (trace_errs(word, W + 4) !== 0) begin
            fails++; $display("FAIL directed_trace: %0d bad cycles, required 0", trace_errs(word, W + 4));
        end else passes++;
        checks++;
        if (res !== W + 5) begin
            fails++; $display("FAIL directed_latency: out_valid at cycle %0d, required %0d", res, W + 5);
        end else passes++;
        checks++;
        if (fec_out !== fec || out_err !== 1'b0 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL directed_result: fec_out=%h out_err=%b out_valid=%b, required %h 0 1",
                     fec_out, out_err, out_valid, fec);
        end else passes++;
        release_result();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL directed_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end else passes++;
    endtask

    task automatic test_random_frames();
        for (int t = 0; t < 8; t++) begin
            logic [W-1:0] word = rand_word();
            logic [W-1:0] fec  = rand_word();
            int d = $urandom_range(W + 22, 2);
            int want = exp_res(d);
            int res;
            run_req(word, d, fec, 200, res);
            checks++;
            if (res !== want) begin
                fails++; $display("FAIL rand_latency[%0d]: done@%0d result@%0d, required %0d", t, d, res, want);
            end else passes++;
            checks++;
            if (trace_errs(word, want) !== 0) begin
                fails++; $display("FAIL rand_trace[%0d]: %0d bad cycles, required 0", t, trace_errs(word, want));
            end else passes++;
            checks++;
            if (fec_out !== fec || out_err !== 1'b0) begin
                fails++; $display("FAIL rand_result[%0d]: fec_out=%h out_err=%b, required %h 0", t, fec_out, out_err, fec);
            end else passes++;
            release_result();
            checks++;
            if (in_ready !== 1'b1) begin
                fails++; $display("FAIL rand_release[%0d]: in_ready=%b, required 1", t, in_ready);
            end else passes++;
        end
    endtask

    task automatic test_done_last_bit();
        logic [W-1:0] word = rand_word();
        logic [W-1:0] fec  = rand_word();
        int res;
        run_req(word, W + 1, fec, 200, res);
        checks++;
        if (res !== W + 3) begin
            fails++; $display("FAIL lastbit_latency: result@%0d, required %0d", res, W + 3);
        end else passes++;
        checks++;
        if (fec_out !== fec || out_err !== 1'b0) begin
            fails++; $display("FAIL lastbit_result: fec_out=%h out_err=%b, required %h 0", fec_out, out_err, fec);
        end else passes++;
        release_result();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] word = rand_word();
        logic [W-1:0] fec  = rand_word();
        int res;
        run_req(word, 10, fec, 200, res);
        in_valid = 1'b1;
        in_word  = rand_word();
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1 crc_fec = rand_word();
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || fec_out !== fec || in_ready !== 1'b0 || crc_start !== 1'b0) begin
                fails++;
                $display("FAIL hold[%0d]: out_valid=%b fec_out=%h in_ready=%b crc_start=%b, required 1 %h 0 0",
                         c, out_valid, fec_out, in_ready, crc_start, fec);
            end else passes++;
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1 || crc_start !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL hold_release: in_ready=%b crc_start=%b out_valid=%b, required 1 0 0",
                     in_ready, crc_start, out_valid);
        end else passes++;
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (crc_start !== 1'b1) begin
            fails++; $display("FAIL next_accept: crc_start=%b, required 1", crc_start);
        end else passes++;
        do_reset();
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] word = rand_word();
        logic [W-1:0] fec  = rand_word();
        int res;
        in_word  = word;
        in_valid = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            @(posedge clock);
            #1;
            in_valid = 1'b0;
            reset    = (c == 22);
            @(negedge clock);
            if (c == 22) begin
                checks++;
                if (crc_data !== word[W - 1 - 20]) begin
                    fails++; $display("FAIL bit20: crc_data=%b, required %b", crc_data, word[W - 1 - 20]);
                end else passes++;
            end
        end
        checks++;
        if (in_ready !== 1'b1 || crc_data !== 1'b0 || out_valid !== 1'b0 || crc_start !== 1'b0) begin
            fails++;
            $display("FAIL reset_shift: in_ready=%b crc_data=%b out_valid=%b crc_start=%b, required 1 0 0 0",
                     in_ready, crc_data, out_valid, crc_start);
        end else passes++;
        run_req(rand_word(), 5, fec, 200, res);
        checks++;
        if (out_valid !== 1'b1 || fec_out !== fec) begin
            fails++; $display("FAIL pre_reset_result: out_valid=%b fec_out=%h, required 1 %h", out_valid, fec_out, fec);
        end else passes++;
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || fec_out !== '0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_result: out_valid=%b fec_out=%h out_err=%b in_ready=%b, required 0 0 0 1",
                     out_valid, fec_out, out_err, in_ready);
        end else passes++;
    endtask

    task automatic test_timeout();
        logic [W-1:0] word = rand_word();
        int res;
`ifdef CRC_SEQ_TIMEOUT_EN
        run_req(word, -1, rand_word() | 48'h1, W + 2 + TO + 10, res);
        checks++;
        if (res !== W + 2 + TO) begin
            fails++; $display("FAIL timeout_latency: result@%0d, required %0d", res, W + 2 + TO);
        end else passes++;
        checks++;
        if (out_err !== 1'b1 || fec_out !== '0) begin
            fails++; $display("FAIL timeout_result: out_err=%b fec_out=%h, required 1 0", out_err, fec_out);
        end else passes++;
        release_result();
`else
        run_req(word, -1, rand_word(), W + 2 + TO + 40, res);
        checks++;
        if (res !== -1) begin
            fails++; $display("FAIL wait_forever: result@%0d, required none", res);
        end else passes++;
        checks++;
        if (out_err !== 1'b0 || trace_errs(word, W + 2 + TO + 40) !== 0) begin
            fails++; $display("FAIL wait_trace: out_err=%b bad=%0d, required 0 0", out_err, trace_errs(word, W + 2 + TO + 40));
        end else passes++;
        do_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_directed_frame();
        test_random_frames();
        test_done_last_bit();
        test_backpressure();
        test_reset_mid();
        test_timeout();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/crc_sequencer.md
CRC_SEQUENCER -- requirements
Module: crc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 48, giving the message length in bits and the width of the FEC result.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the maximum WAIT cycles for crc_done.
REQ-003 The block SHALL have port clock, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the requester offers in_word.
REQ-006 The block SHALL have port in_word, input, WIDTH bits: the message, transmitted MSB first.
REQ-007 The block SHALL have port in_ready, output, 1 bit: high only in IDLE.
REQ-008 The block SHALL have port crc_start, output, 1 bit: one-cycle start pulse to the CRC engine.
REQ-009 The block SHALL have port crc_data, output, 1 bit: the serial message bit to the CRC engine.
REQ-010 The block SHALL have port crc_done, input, 1 bit: completion flag from the CRC engine.
REQ-011 The block SHALL have port crc_fec, input, WIDTH bits: result from the CRC engine.
REQ-012 The block SHALL have port out_valid, output, 1 bit: fec_out and out_err are valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 The block SHALL have port fec_out, output, WIDTH bits: the captured FEC.
REQ-015 The block SHALL have port out_err, output, 1 bit: a timeout occurred; fec_out is invalid.

Function
REQ-016 The FSM SHALL have the states IDLE, START, SHIFT, WAIT and RESULT.
REQ-017 In IDLE, when in_valid=1 (in_ready=1), the block SHALL latch in_word into the shift register and go to START.
REQ-018 In START, the block SHALL drive crc_start=1 and crc_data=0 for exactly one cycle, then go to SHIFT with bit counter=0.
REQ-019 In SHIFT, crc_data SHALL equal the shift register MSB.
REQ-020 In SHIFT, the shift register SHALL shift left by one with zero fill each cycle, and the counter SHALL increment.
REQ-021 After WIDTH SHIFT cycles (counter WIDTH-1), the block SHALL go to WAIT.
REQ-022 Latency: acceptance at cycle 0, crc_start in cycle 1, message bits in cycles 2..WIDTH+1, with bit k (0 = MSB) in cycle k+2.
REQ-023 A sticky done flag SHALL set when crc_done=1 in any SHIFT or WAIT cycle, and clear on entry to START.
REQ-024 In WAIT, when the done flag or crc_done is set, the block SHALL capture crc_fec into fec_out, set out_err=0, and go to RESULT.
REQ-025 If done was flagged during SHIFT, the block SHALL capture crc_fec on the first WAIT cycle.
REQ-026 In RESULT, out_valid SHALL be 1 and fec_out/out_err SHALL be held stable.
REQ-027 In RESULT, out_valid and out_ready both 1 SHALL return the block to IDLE the next cycle.
REQ-028 A new request SHALL be accepted no earlier than the cycle after the RESULT handshake.
REQ-029 in_valid outside IDLE SHALL be ignored; in_word need not stay stable after acceptance.
REQ-030 crc_start SHALL be 0 in all states except START.
REQ-031 crc_data SHALL be 0 in all states except SHIFT.

Reset
REQ-032 Reset SHALL take the FSM to IDLE and take priority over all other inputs, including mid-SHIFT and mid-RESULT.
REQ-033 Reset SHALL clear the counter, shift register, done flag, fec_out, out_err, out_valid, crc_start and crc_data to 0.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-035 The macro CRC_SEQ_TIMEOUT_EN SHALL control the WAIT timeout.
REQ-036 With CRC_SEQ_TIMEOUT_EN defined, a WAIT cycle counter SHALL run.
REQ-037 With CRC_SEQ_TIMEOUT_EN defined, reaching TIMEOUT WAIT cycles without done SHALL send the block to RESULT with out_err=1 and fec_out=0.
REQ-038 With CRC_SEQ_TIMEOUT_EN undefined, WAIT SHALL hold until done indefinitely, and out_err SHALL be tied to 0.

Verification
REQ-039 The bench SHALL cover: in_word=48'h03_01_02_03_30_3A accepted -> crc_start high one cycle; crc_data sequence 0,0,0,0,0,0,1,1,... (MSB first) over 48 cycles.
REQ-040 The bench SHALL cover: crc_done pulses 3 cycles after the last bit with crc_fec=48'h1234_5678_9ABC -> fec_out=48'h1234_5678_9ABC, out_err=0, out_valid=1.
REQ-041 The bench SHALL cover: crc_done pulses during the last SHIFT cycle only -> captured on the first WAIT cycle and RESULT reached.
REQ-042 The bench SHALL cover: out_ready held 0 for 10 cycles, plus in_valid=1 -> out_valid and fec_out stable and in_ready=0; out_ready=1 -> IDLE, next word accepted one cycle later.
REQ-043 The bench SHALL cover: reset asserted at bit 20 -> next cycle IDLE, crc_data=0, out_valid=0, in_ready=1.
REQ-044 The bench SHALL cover: with CRC_SEQ_TIMEOUT_EN defined and crc_done held 0 -> RESULT after 64 WAIT cycles with out_err=1, fec_out=0.
